// File: rtl/gcd_sched_if.sv
// gcd_sched_if: request, response and engine channels of the shared-GCD scheduler
interface gcd_sched_if #(parameter int NREQ = 4, parameter int W = 32);
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [W-1:0] rsp_c, eng_a, eng_b, eng_c;
  logic eng_start, eng_abort, eng_done;
  modport slave (
    input req_valid, req_a, req_b, rsp_ready, eng_done, eng_c,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, eng_start, eng_a, eng_b, eng_abort
  );
  modport master (
    output req_valid, req_a, req_b, rsp_ready, eng_done, eng_c,
    input req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, eng_start, eng_a, eng_b, eng_abort
  );
endinterface

// File: rtl/gcd_sched.sv
// gcd_sched: round-robin scheduler sharing one iterative GCD engine among NREQ requesters
module gcd_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input logic        clk,
  input logic        reset,
  gcd_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, id_q, id_d, gnt_id, idx;
  logic [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, sel_a, sel_b;
  logic [W-1:0] ra [NREQ];
  logic [W-1:0] rb [NREQ];
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, gnt_ok, byp, tmo;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ra[i] = bus.req_a[i*W +: W];
    assign rb[i] = bus.req_b[i*W +: W];
  end
  // scan downward so the requester closest after last_q is the one left standing
  always_comb begin
    gnt_ok = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % NREQ);
      if (bus.req_valid[idx]) begin
        gnt_ok = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign sel_a = ra[gnt_id];
  assign sel_b = rb[gnt_id];
  assign byp = sel_a == '0 || sel_b == '0;
  assign tmo = state_q == WAIT && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    err_d = err_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (gnt_ok) begin
        last_d = gnt_id;
        id_d = gnt_id;
        a_d = sel_a;
        b_d = sel_b;
        c_d = byp ? (sel_a | sel_b) : c_q;
        err_d = byp ? 1'b0 : err_q;
        state_d = byp ? RESP : ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        c_d = bus.eng_done ? bus.eng_c : tmo ? '0 : c_q;
        err_d = bus.eng_done ? 1'b0 : tmo ? 1'b1 : err_q;
        state_d = (bus.eng_done || tmo) ? RESP : WAIT;
      end
      default: state_d = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q <= IW'(NREQ - 1);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.req_ready = (reset && state_q == IDLE && gnt_ok) ? NREQ'(1) << gnt_id : '0;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_id = id_q;
  assign bus.rsp_c = c_q;
  assign bus.rsp_err = err_q;
  assign bus.eng_start = state_q == ISSUE;
  assign bus.eng_abort = tmo && !bus.eng_done;
  assign bus.eng_a = a_q;
  assign bus.eng_b = b_q;
endmodule

// File: tb/tb_gcd_sched.sv
// tb_gcd_sched: vector table, directed corner cases and randomized traffic checked against a reference model
module tb_gcd_sched;
  localparam int NREQ = 4;
  localparam int W = 32;
  localparam int TMO = 16;
  typedef struct {
    int id;
    logic [W-1:0] a, b;
    int lat;
    logic [W-1:0] c;
    logic err;
    int n;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  gcd_sched_if #(.NREQ(NREQ), .W(W)) bus ();
  gcd_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int n_cmp = 0;
  int n_err = 0;
  int mlast = NREQ - 1;
  int eng_lat = 0;
  int m_left;
  logic m_done, stray_done = 1'b0;
  logic [W-1:0] m_c, stray_c = '0;
  function automatic logic [W-1:0] gcd(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  function automatic logic [W:0] ref_rsp(logic [W-1:0] a, logic [W-1:0] b, int lat);
    if (a == 0 || b == 0) return {1'b0, a | b};
    if (lat >= 1 && lat <= TMO) return {1'b0, gcd(a, b)};
    return {1'b1, {W{1'b0}}};
  endfunction
  function automatic int rr_pick(int last, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction
  // engine: result after eng_lat cycles (0 = never), cancelled by abort
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_c <= '0;
    end else begin
      m_done <= (bus.eng_start && eng_lat == 1) || (!bus.eng_start && !bus.eng_abort && m_left == 2);
      if (bus.eng_start) begin
        m_left <= eng_lat;
        m_c <= gcd(bus.eng_a, bus.eng_b);
      end else if (bus.eng_abort) m_left <= 0;
      else if (m_left != 0) m_left <= m_left - 1;
    end
  end
  assign bus.eng_done = m_done | stray_done;
  assign bus.eng_c = stray_done ? stray_c : m_c;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    mlast = NREQ - 1;
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'(0));
    chk({tag, "_rsp_c"}, 64'(bus.rsp_c), 64'(0));
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
    chk({tag, "_eng_start"}, 64'(bus.eng_start), 64'(0));
    chk({tag, "_eng_abort"}, 64'(bus.eng_abort), 64'(0));
    chk({tag, "_eng_a"}, 64'(bus.eng_a), 64'(0));
    chk({tag, "_eng_b"}, 64'(bus.eng_b), 64'(0));
  endtask
  // one full transaction: grant to w, engine/bypass path, hold, handshake
  task automatic serve(int w, int lat, logic [W-1:0] ec, logic ee, int en, bit drop, int hold);
    logic [W-1:0] a, b;
    int n, n_st, n_ab, st_cnt, ab_cnt;
    bit bad, byp;
    eng_lat = lat;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 50) begin
      tick();
      n++;
    end
    chk("grant", 64'(bus.req_ready), 64'(1) << w);
    a = bus.req_a[w*W +: W];
    b = bus.req_b[w*W +: W];
    byp = a == 0 || b == 0;
    mlast = w;
    tick();
    if (drop) begin
      bus.req_valid[w] = 1'b0;
      set_req(w, W'($urandom), W'($urandom));
    end
    n = 1;
    n_st = 0;
    n_ab = 0;
    st_cnt = 0;
    ab_cnt = 0;
    bad = 1'b0;
    while (!bus.rsp_valid && n < 60) begin
      if (bus.eng_start) begin
        st_cnt++;
        n_st = n;
      end
      if (bus.eng_abort) begin
        ab_cnt++;
        n_ab = n;
      end
      if (bus.req_ready != '0 || bus.eng_a != a || bus.eng_b != b) bad = 1'b1;
      tick();
      n++;
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk("latency", 64'(n), 64'(en));
    chk("rsp_id", 64'(bus.rsp_id), 64'(w));
    chk("rsp_c", 64'(bus.rsp_c), 64'(ec));
    chk("rsp_err", 64'(bus.rsp_err), 64'(ee));
    chk("busy_stable", 64'(bad), 64'(0));
    chk("start_cnt", 64'(st_cnt), byp ? 64'(0) : 64'(1));
    chk("abort_cnt", 64'(ab_cnt), 64'(ee));
    if (st_cnt == 1) chk("start_at", 64'(n_st), 64'(1));
    if (ab_cnt == 1) chk("abort_at", 64'(n_ab - n_st), 64'(TMO));
    bad = 1'b0;
    for (int k = 0; k < hold; k++) begin
      stray_done = k == 0;
      stray_c = 32'hDEAD_BEEF;
      tick();
      stray_done = 1'b0;
      if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != w || bus.rsp_c != ec || bus.rsp_err != ee || bus.req_ready != '0) bad = 1'b1;
    end
    if (hold > 0) chk("hold_stable", 64'(bad), 64'(0));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 64'(bus.rsp_valid), 64'(0));
  endtask
  vec_t tbl[10];
  logic [W-1:0] pa[NREQ], pb[NREQ], pc[NREQ];
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    tbl[0] = '{0, 161, 14, 5, 7, 1'b0, 7};
    tbl[1] = '{1, 0, 14, 3, 14, 1'b0, 1};
    tbl[2] = '{2, 0, 0, 3, 0, 1'b0, 1};
    tbl[3] = '{3, 9, 0, 3, 9, 1'b0, 1};
    tbl[4] = '{0, 48, 18, 0, 0, 1'b1, TMO + 2};
    tbl[5] = '{1, 48, 18, TMO, 6, 1'b0, TMO + 2};
    tbl[6] = '{2, 48, 18, TMO + 1, 0, 1'b1, TMO + 2};
    tbl[7] = '{3, 100, 75, 1, 25, 1'b0, 3};
    tbl[8] = '{0, 1, 1, 2, 1, 1'b0, 4};
    tbl[9] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF, 1'b0, 6};
    pa = '{48, 100, 17, 36};
    pb = '{18, 75, 5, 60};
    pc = '{6, 25, 1, 12};
    tick();
    check_zero("reset");
    reset = 1'b1;
    #1;
    chk("reset_priority", 64'(bus.req_ready), 64'(1));
    bus.req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      set_req(tbl[i].id, tbl[i].a, tbl[i].b);
      bus.req_valid[tbl[i].id] = 1'b1;
      serve(tbl[i].id, tbl[i].lat, tbl[i].c, tbl[i].err, tbl[i].n, 1'b1, 2);
    end
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, pa[i], pb[i]);
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) serve(k % NREQ, 3, pc[k % NREQ], 1'b0, 5, 1'b0, 0);
    do_reset();
    bus.req_valid = '1;
    serve(0, 2, 6, 1'b0, 4, 1'b0, 10);
    #1;
    chk("bp_next_grant", 64'(bus.req_ready), 64'(2));
    serve(1, 2, 25, 1'b0, 4, 1'b1, 0);
    bus.req_valid = '0;
    do_reset();
    set_req(0, 48, 18);
    set_req(2, 36, 60);
    eng_lat = 0;
    bus.req_valid = 4'b0001;
    #1;
    chk("mid_grant0", 64'(bus.req_ready), 64'(1));
    tick();
    chk("mid_start", 64'(bus.eng_start), 64'(1));
    tick();
    tick();
    tick();
    #3;
    reset = 1'b0;
    bus.req_valid = 4'b0101;
    #1;
    check_zero("mid_reset");
    begin
      bit bad = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (bus.rsp_valid || bus.req_ready != '0) bad = 1'b1;
      end
      chk("mid_no_rsp", 64'(bad), 64'(0));
    end
    reset = 1'b1;
    mlast = NREQ - 1;
    #1;
    chk("post_reset_grant", 64'(bus.req_ready), 64'(1));
    serve(0, 3, 6, 1'b0, 5, 1'b1, 0);
    serve(2, 3, 12, 1'b0, 5, 1'b1, 0);
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] m;
      logic [W-1:0] a, b;
      logic [W:0] r;
      int w, lat, f;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        f = $urandom_range(1, 40);
        set_req(i, ($urandom_range(0, 5) == 0) ? '0 : W'(f * $urandom_range(1, 300)),
                   ($urandom_range(0, 5) == 0) ? '0 : W'(f * $urandom_range(1, 300)));
      end
      bus.req_valid = m;
      lat = $urandom_range(1, 20);
      w = rr_pick(mlast, m);
      a = bus.req_a[w*W +: W];
      b = bus.req_b[w*W +: W];
      r = ref_rsp(a, b, lat);
      serve(w, lat, r[W-1:0], r[W], (a == 0 || b == 0) ? 1 : (lat <= TMO ? lat + 2 : TMO + 2), 1'b1, $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
Round-robin scheduler that shares one iterative GCD engine among NREQ requesters. It accepts an operand pair from one requester, issues the pair to the engine with a start pulse, and waits for done or a timeout. It then returns the result tagged with the requester ID over a valid/ready response channel. Zero operands are resolved locally without using the engine.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, operand/result width
TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester request valid
req_a  input  NREQ*W  operand a, requester i at bits [i*W +: W]
req_b  input  NREQ*W  operand b, same packing
req_ready  output  NREQ  one-hot grant/accept
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  $clog2(NREQ)  requester index of response
rsp_c  output  W  GCD result
rsp_err  output  1  engine timed out
eng_start  output  1  one-cycle start pulse to engine
eng_a  output  W  operand a to engine, held from start until done/abort
eng_b  output  W  operand b to engine, same hold rule
eng_abort  output  1  one-cycle abort pulse on timeout
eng_done  input  1  engine result valid (single-cycle)
eng_c  input  W  engine result, sampled when eng_done=1

Behaviour:
- Reset (reset=0, async): state=IDLE; rsp_valid, rsp_id, rsp_c, rsp_err, eng_start, eng_abort, eng_a, eng_b, timeout counter = 0; last-grant pointer = NREQ-1, so requester 0 has top priority. req_ready forced to 0 while reset=0.
- Arbitration: the winner is the first requester with req_valid=1 scanning from last_grant+1 modulo NREQ. req_ready is combinational: one-hot winner only when state=IDLE, else all 0.
- Transfer occurs on the edge where req_valid[i]&req_ready[i]. At that edge:
  - req_a[i] and req_b[i] are captured.
  - id is captured and last_grant<=i.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On transfer with captured a==0 or b==0 -> RESP, with rsp_c = a|b (gcd(0,0)=0) and rsp_err=0. No eng_start is issued.
  - On any other transfer -> ISSUE.
- ISSUE: eng_start=1 for exactly this cycle; eng_a/eng_b are valid. Counter is cleared. -> WAIT.
- WAIT:
  - Counter increments each cycle.
  - If eng_done=1: rsp_c<=eng_c, rsp_err<=0 -> RESP.
  - Else if counter==TIMEOUT-1: rsp_c<=0, rsp_err<=1, eng_abort=1 for one cycle -> RESP.
  - If eng_done and timeout coincide, done wins.
- RESP:
  - rsp_valid=1. rsp_id, rsp_c and rsp_err are held stable until rsp_ready=1.
  - On the rsp_valid&rsp_ready edge -> IDLE. The next grant may occur the following cycle.
- eng_done outside WAIT is ignored.
- Latency:
  - Engine path: accept at cycle T, eng_start at T+1. Done at T+1+L gives rsp_valid at T+2+L.
  - Zero bypass: rsp_valid at T+1.
- Fairness: at most one request is in flight. A continuously requesting requester waits at most NREQ-1 grants.
- Operands are captured at accept. Requester changes to req_a/req_b afterwards have no effect.
- Reset mid-operation aborts immediately and returns all outputs to reset values; no response is generated. The engine shares the same reset.
- Counter width is $clog2(TIMEOUT+1). The counter never wraps, since WAIT exits at TIMEOUT-1.

Test Plan:
1. Single request, requester 0: a=161, b=14, engine model latency 5. Required: req_ready[0] in the accept cycle, eng_start exactly one cycle later with eng_a=161, eng_b=14. Response rsp_valid with rsp_id=0, rsp_c=7, rsp_err=0, 7 cycles after accept.
2. All four requesters valid continuously, pairs (48,18), (100,75), (17,5), (36,60), rsp_ready=1. Required: grant order 0,1,2,3,0 and results 6, 25, 1, 12, 6, with the matching rsp_id for each.
3. Zero bypass: (0,14) -> rsp_c=14 one cycle after accept. (0,0) -> rsp_c=0. (9,0) -> rsp_c=9. No eng_start in any of the three cases.
4. Timeout: TIMEOUT=16 and the engine never asserts done. Required: eng_abort pulses 16 cycles after eng_start, then rsp_err=1 and rsp_c=0. An eng_done arriving later is ignored. A coincident done at cycle 15 yields rsp_err=0.
5. Backpressure: hold rsp_ready=0 for 10 cycles with other requesters valid. Required: rsp_valid, rsp_id and rsp_c stay stable and all req_ready remain 0. After rsp_ready=1 is accepted, the next round-robin winner is granted the following cycle.
6. Reset mid-WAIT: assert reset low asynchronously. Required: all outputs 0 immediately and no response is emitted. After release, with requesters 2 and 0 both valid, requester 0 is granted first.
